// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan driver: hex font, FSM states, digit entry.
// Latency: n/a (constants, types and a pure function).
// Backpressure: n/a.
package seg7_pkg;

    // Scan FSM: a short all-off gap at the start of each slot, then the digit is driven.
    typedef enum logic {
        BLANK_GAP = 1'b0,
        DRIVE     = 1'b1
    } scan_state_e;

    // One stored display position.
    typedef struct packed {
        logic [3:0] nib;
        logic       dp;
    } digit_t;

    localparam int PRESC_W = 16;

    // Segment patterns, bit 0 = a ... bit 6 = g. Glyphs 0-9, A, b, C, d, E, F.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        return HEX_SEG[nib];
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to 7-segment pattern decoder.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: nibble_i - hex value 0..F; seg_o - segments a..g, bit 0 = a, active-high.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment display driver with digit store, scan FSM and anti-ghosting gap.
// Latency: stored value to pins 1 clock; write strobe to pins 2 edges; blank next edge.
// Backpressure: none - the write port is accepted every cycle; out-of-range writes are dropped.
// Ports: clk/rst (async active-high); wr_en/wr_addr/wr_data/wr_dp write the digit store;
//        lz_supp enables leading-zero blanking; blank forces the display off;
//        seg (a..g, bit 0 = a), dp, dig_en (one-hot digit select) are registered pins.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [2:0]            wr_addr,
    input  logic [3:0]            wr_data,
    input  logic                  wr_dp,
    input  logic                  lz_supp,
    input  logic                  blank,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] dig_en
);

    localparam int                 IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    // ------------------------------------------------------------------
    // Digit store
    // ------------------------------------------------------------------
    digit_t store_q [NUM_DIGITS];

    // Address match per entry means addresses >= NUM_DIGITS simply hit nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                store_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (wr_en && (wr_addr == 3'(i))) begin
                    store_q[i] <= {wr_data, wr_dp};
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan state
    // ------------------------------------------------------------------
    logic [PRESC_W-1:0]    presc_q, presc_d;
    logic [IDX_W-1:0]      scan_q, scan_d;
    scan_state_e           state_q, state_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;

    digit_t     cur_dig;
    logic       hi_zero;
    logic       lz_blank;
    logic       presc_wrap;
    logic [6:0] dec_seg;

    // Select the entry under the scan index and decide leading-zero blanking:
    // the digit is blanked only if it and every higher-index digit are zero.
    always_comb begin
        cur_dig = '0;
        hi_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_q == IDX_W'(i)) begin
                cur_dig = store_q[i];
            end
            if ((IDX_W'(i) >= scan_q) && (store_q[i].nib != 4'h0)) begin
                hi_zero = 1'b0;
            end
        end
        lz_blank = lz_supp && hi_zero && (scan_q != '0);
    end

    seg7_hex_decode u_hex_decode (
        .nibble_i (cur_dig.nib),
        .seg_o    (dec_seg)
    );

    // state_q always classifies presc_q, so the outputs registered from it
    // trail the prescaler by one edge: the gap covers prescaler 0..1 and the
    // first driven edge after reset is the third one.
    always_comb begin
        presc_wrap = (presc_q == PRESC_LAST);
        presc_d    = presc_wrap ? '0 : presc_q + PRESC_W'(1);

        scan_d = scan_q;
        if (presc_wrap) begin
            scan_d = (scan_q == IDX_LAST) ? '0 : scan_q + IDX_W'(1);
        end

        state_d = (presc_d >= PRESC_W'(2)) ? DRIVE : BLANK_GAP;

        seg_d    = '0;
        dp_d     = 1'b0;
        dig_en_d = '0;
        // blank only masks the pins; prescaler and scan index keep running.
        if (!blank && (state_q == DRIVE)) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                dig_en_d[i] = (scan_q == IDX_W'(i));
            end
            seg_d = lz_blank ? 7'h00 : dec_seg;
            dp_d  = cur_dig.dp;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q  <= '0;
            scan_q   <= '0;
            state_q  <= BLANK_GAP;
            seg_q    <= '0;
            dp_q     <= 1'b0;
            dig_en_q <= '0;
        end else begin
            presc_q  <= presc_d;
            scan_q   <= scan_d;
            state_q  <= state_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            dig_en_q <= dig_en_d;
        end
    end

    // Polarity is applied after the registers so it adds no latency and the
    // reset value (all zero) becomes the inactive pin level either way.
    assign seg    = ACTIVE_LOW ? ~seg_q    : seg_q;
    assign dp     = ACTIVE_LOW ? ~dp_q     : dp_q;
    assign dig_en = ACTIVE_LOW ? ~dig_en_q : dig_en_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (NUM_DIGITS=4, SCAN_DIV=8), both pin polarities.
// Latency: n/a.
// Backpressure: n/a.
module tb_seg7_scan_driver;

    localparam int N      = 4;
    localparam int DIV    = 8;
    localparam int PERIOD = N * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic       wr_dp = 1'b0;
    logic       lz_supp = 1'b0;
    logic       blank = 1'b0;

    logic [6:0]   seg_h, seg_l;
    logic         dp_h, dp_l;
    logic [N-1:0] dig_h, dig_l;

    always #5 clk = ~clk;

    seg7_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(DIV), .ACTIVE_LOW(1'b0)) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_dp(wr_dp), .lz_supp(lz_supp), .blank(blank),
        .seg(seg_h), .dp(dp_h), .dig_en(dig_h)
    );

    seg7_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(DIV), .ACTIVE_LOW(1'b1)) u_dut_al (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_dp(wr_dp), .lz_supp(lz_supp), .blank(blank),
        .seg(seg_l), .dp(dp_l), .dig_en(dig_l)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the displayed digit is a pure function of how many
    // edges have elapsed since reset release.
    logic [3:0] m_nib [N];
    logic       m_dp  [N];
    int         k;
    logic [6:0] font  [16];

    typedef struct {
        logic [3:0] nib;
        logic       dp;
        logic [6:0] exp_seg;
    } vec_t;
    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    // Expected {seg, dp, dig_en} produced by the upcoming edge.
    function automatic logic [11:0] model_pins();
        int         presc = k % DIV;
        int         idx   = (k / DIV) % N;
        logic [6:0] s;
        logic [3:0] de;
        logic       hz;
        if (blank || presc < 2) return 12'h000;
        s = font[m_nib[idx]];
        if (lz_supp && idx != 0) begin
            hz = 1'b1;
            for (int j = idx; j < N; j++) if (m_nib[j] != 4'h0) hz = 1'b0;
            if (hz) s = 7'h00;
        end
        de = 4'(1 << idx);
        return {s, m_dp[idx], de};
    endfunction

    task automatic step();
        logic [11:0] exp, expi;
        int          a;
        exp  = model_pins();
        expi = ~exp;
        a    = int'(wr_addr);
        if (wr_en && a < N) begin
            m_nib[a] = wr_data;
            m_dp[a]  = wr_dp;
        end
        @(posedge clk);
        #1;
        k++;
        chk("model_pins", {seg_h, dp_h, dig_h}, exp);
        chk("model_pins_al", {seg_l, dp_l, dig_l}, expi);
    endtask

    task automatic wr(input int a, input logic [3:0] d, input logic p);
        wr_en   = 1'b1;
        wr_addr = 3'(a);
        wr_data = d;
        wr_dp   = p;
        step();
        wr_en   = 1'b0;
    endtask

    // Advance so that the last edge taken was the first driven edge of slot s.
    task automatic wait_slot(input int s);
        while ((k % PERIOD) != s * DIV + 2) step();
        chk("gap_before_slot", 32'(dig_h), 32'h0);
        step();
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_nib[i] = 4'h0;
            m_dp[i]  = 1'b0;
        end
        k = 0;
    endtask

    task automatic first_slot_after_reset();
        step(); chk("post_rst_edge1_dig", 32'(dig_h), 32'h0);
        step(); chk("post_rst_edge2_dig", 32'(dig_h), 32'h0);
        step(); chk("post_rst_edge3_dig", 32'(dig_h), 32'h1);
    endtask

    initial begin
        logic [6:0] s30 [4];
        logic [6:0] s31 [4];
        logic [6:0] old_seg;
        int         idx;

        font = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        vecs = '{
            '{4'h0, 1'b0, 7'h3F}, '{4'h1, 1'b1, 7'h06}, '{4'h2, 1'b0, 7'h5B}, '{4'h3, 1'b1, 7'h4F},
            '{4'h4, 1'b0, 7'h66}, '{4'h5, 1'b1, 7'h6D}, '{4'h6, 1'b0, 7'h7D}, '{4'h7, 1'b1, 7'h07},
            '{4'h8, 1'b0, 7'h7F}, '{4'h9, 1'b1, 7'h6F}, '{4'hA, 1'b0, 7'h77}, '{4'hB, 1'b1, 7'h7C},
            '{4'hC, 1'b0, 7'h39}, '{4'hD, 1'b1, 7'h5E}, '{4'hE, 1'b0, 7'h79}, '{4'hF, 1'b1, 7'h71}
        };
        s30 = '{7'h06, 7'h5B, 7'h4F, 7'h66};
        s31 = '{7'h3F, 7'h6D, 7'h00, 7'h00};

        // Power-on reset: pins inactive while held.
        #1 rst = 1'b1;
        #2;
        chk("reset_pins", {seg_h, dp_h, dig_h}, 12'h000);
        chk("reset_pins_al", {seg_l, dp_l, dig_l}, 12'hFFF);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
        first_slot_after_reset();

        // Digits 0..3 = 1..4, one full scan.
        for (int i = 0; i < N; i++) wr(i, 4'(i + 1), 1'b0);
        for (int s = 0; s < N; s++) begin
            wait_slot(s);
            chk("scan_seg", 32'(seg_h), 32'(s30[s]));
            chk("scan_dig", 32'(dig_h), 32'(1 << s));
        end

        // Hex font table through digit 0.
        for (int v = 0; v < 16; v++) begin
            wr(0, vecs[v].nib, vecs[v].dp);
            wait_slot(0);
            chk("font_seg", 32'(seg_h), 32'(vecs[v].exp_seg));
            chk("font_dp", 32'(dp_h), 32'(vecs[v].dp));
        end

        // Inverted pins: digit 0 = 8 with dp.
        wr(0, 4'h8, 1'b1);
        wait_slot(0);
        chk("al_seg", 32'(seg_l), 32'h00);
        chk("al_dp", 32'(dp_l), 32'h0);
        chk("al_dig", 32'(dig_l), 32'hE);

        // Leading-zero suppression: digits 3..0 = 0,0,5,0.
        lz_supp = 1'b1;
        wr(3, 4'h0, 1'b0);
        wr(2, 4'h0, 1'b0);
        wr(1, 4'h5, 1'b0);
        wr(0, 4'h0, 1'b0);
        for (int s = 0; s < N; s++) begin
            wait_slot(s);
            chk("lz_seg", 32'(seg_h), 32'(s31[s]));
            chk("lz_dig", 32'(dig_h), 32'(1 << s));
        end
        lz_supp = 1'b0;

        // Write to the digit being driven, mid-slot.
        while ((k % DIV) != 3) step();
        idx     = (k / DIV) % N;
        old_seg = font[m_nib[idx]];
        wr(idx, 4'hF, 1'b0);
        chk("live_wr_edge1", 32'(seg_h), 32'(old_seg));
        step();
        chk("live_wr_edge2", 32'(seg_h), 32'h71);

        // Out-of-range address is dropped.
        wr(6, 4'h8, 1'b1);
        for (int s = 0; s < N; s++) begin
            wait_slot(s);
            chk("oor_wr_seg", 32'(seg_h), (s == idx) ? 32'h71 : 32'(font[m_nib[s]]));
        end

        // Global blank for 20 cycles; scanning continues underneath.
        blank = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            chk("blank_pins", {seg_h, dp_h, dig_h}, 12'h000);
        end
        blank = 1'b0;
        while ((k % DIV) != 2) step();
        step();
        chk("blank_resume_dig", 32'(dig_h), 32'(1 << (((k - 1) / DIV) % N)));

        // Asynchronous reset in the middle of a driven slot.
        while ((k % DIV) != 4) step();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_pins", {seg_h, dp_h, dig_h}, 12'h000);
        chk("async_rst_pins_al", {seg_l, dp_l, dig_l}, 12'hFFF);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
        first_slot_after_reset();
        for (int s = 1; s < N; s++) begin
            wait_slot(s);
            chk("cleared_digit", 32'(seg_h), 32'h3F);
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 800; c++) begin
            if ((c % 64) == 0) lz_supp = 1'($urandom_range(0, 1));
            blank   = ($urandom_range(0, 19) == 0);
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = 3'($urandom_range(0, 7));
            wr_data = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            wr_dp   = 1'($urandom_range(0, 1));
            step();
        end
        wr_en = 1'b0;
        blank = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
